// File: rtl/mem_bus_pkg.sv
// Shared definitions for the picorv32 memory-bus fabric: FSM encoding,
// status register layout and the default output-register address.
package mem_bus_pkg;

  // Read-latency sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bus_state_t;

  // Status word layout returned by a read of the output register address.
  localparam int STAT_FREE_LSB = 0;
  localparam int STAT_FREE_W   = 5;
  localparam int STAT_EMPTY    = 8;
  localparam int STAT_ERR      = 31;

  localparam logic [31:0] DEFAULT_OUT_ADDR = 32'h0008_0000;

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO feeding the byte output channel. The head word is
// held in a register so downstream logic sees a flop-driven data bus.
module out_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  // Storage array: written on push only.
  // NOTE: the data array has no reset; only pointers and count need one, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and the registered head word.
  // NOTE: registers use non-blocking (<=) so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_n;
      count  <= count + CW'(do_push) - CW'(do_pop);
      // The new head is the byte being written when it lands in the slot the
      // read pointer is about to point at, otherwise whatever storage holds.
      if (do_push || do_pop) begin
        rdata <= (do_push && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Native memory-bus fabric for picorv32: address decode to NUM_SLV slave
// regions with per-region read latency, a FIFO-buffered byte output port
// with status readback, and a sticky flag for unmapped accesses.
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int                    NUM_SLV    = 3,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE   = {32'h0004_0000, 32'h0002_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK   = {32'hFFFC_0000, 32'hFFFE_0000, 32'hFFFE_0000},
  parameter logic [2*NUM_SLV-1:0]  SLV_RD_LAT = {2'd1, 2'd1, 2'd1},
  parameter logic [31:0]           OUT_ADDR   = DEFAULT_OUT_ADDR,
  parameter int                    OUT_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic [31:0]             mem_rdata,
  output logic [NUM_SLV-1:0]      slv_ce,
  output logic [29:0]             slv_addr,
  output logic [31:0]             slv_wdata,
  output logic [3:0]              slv_wstrb,
  input  logic [32*NUM_SLV-1:0]   slv_rdata,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  input  logic                    out_ready,
  output logic                    bus_err
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam logic [STAT_FREE_W-1:0] DEPTH_FREE = STAT_FREE_W'(OUT_DEPTH);

  bus_state_t              state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    rd_done_q, rd_done_d;
  logic                    bus_err_q, err_set;
  logic                    active;
  logic                    is_write;
  logic                    out_hit;
  logic                    slv_hit;
  logic [IDX_W-1:0]        slv_idx;
  logic [1:0]              slv_lat;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [STAT_FREE_W-1:0]  free_cnt;
  logic [31:0]             status;

  // Reset masks the request so nothing completes while rst is held.
  assign active   = mem_valid && !rst;
  assign is_write = |mem_wstrb;

  // Address decode: the output register beats every slave; among slaves the
  // lowest index wins, so scan from the top and let lower hits overwrite.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out_hit = (mem_addr == OUT_ADDR);
    slv_hit = 1'b0;
    slv_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        slv_hit = 1'b1;
        slv_idx = IDX_W'(i);
      end
    end
  end

  assign slv_lat   = SLV_RD_LAT[2*slv_idx +: 2];
  assign slv_ce    = (active && slv_hit && !out_hit) ? (NUM_SLV'(1) << slv_idx) : '0;
  assign slv_addr  = mem_addr[31:2];
  assign slv_wdata = mem_wdata;
  assign slv_wstrb = (|slv_ce) ? mem_wstrb : 4'h0;

  // Status word: free entries, empty flag and the sticky error flag.
  always_comb begin
    free_cnt = DEPTH_FREE - STAT_FREE_W'(fifo_count);
    status   = '0;
    status[STAT_FREE_LSB +: STAT_FREE_W] = free_cnt;
    status[STAT_EMPTY]                   = fifo_empty;
    status[STAT_ERR]                     = bus_err_q;
  end

  // Next-state and bus responses: zero-wait completions come straight from
  // decode; slave reads are sequenced and finish from the rd_done register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_done_d = 1'b0;
    mem_ready = rd_done_q;
    mem_rdata = '0;
    fifo_push = 1'b0;
    err_set   = 1'b0;
    if (rd_done_q) begin
      mem_rdata = slv_rdata[32*slv_idx +: 32];
    end
    case (state_q)
      ST_IDLE: begin
        // rd_done blocks re-acceptance of the read that is completing now.
        if (active && !rd_done_q) begin
          if (out_hit) begin
            if (is_write) begin
              fifo_push = !fifo_full;
              mem_ready = !fifo_full;
            end else begin
              mem_ready = 1'b1;
              mem_rdata = status;
            end
          end else if (slv_hit) begin
            if (is_write) begin
              mem_ready = 1'b1;
            end else begin
              cnt_d = slv_lat - 2'd1;
              if (slv_lat <= 2'd1) begin
                rd_done_d = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end else begin
            mem_ready = 1'b1;
            err_set   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          rd_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, latency counter, read-done strobe and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_done_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_done_q <= rd_done_d;
      bus_err_q <= bus_err_q | err_set;
    end
  end

  assign fifo_pop  = !fifo_empty && out_ready;
  assign out_valid = !fifo_empty;
  assign bus_err   = bus_err_q;

  out_fifo #(
    .WIDTH (8),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mem_wdata[7:0]),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
